vc_sram_sched: RTL and testbench

VC_SRAM_SCHED -- requirements
Module: vc_sram_sched

---
 rtl/vc_sram_sched.sv | 186 ++++++++++++++++++
 tb/tb_vc_sram_sched.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_sram_sched.sv
// Read/write scheduler for two single-port SRAM instances (a: addr MSB=1, b: addr MSB=0).
// Optional: define VC_SCHED_RAW_CHK_EN to hold reads that match a buffered write address.
module vc_sram_sched #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int TAG_W      = 4,
  parameter int RD_LAT     = 2,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rd_req_vld,
  output logic                          rd_req_rdy,
  input  logic [ADDR_W-1:0]             rd_req_addr,
  input  logic [TAG_W-1:0]              rd_req_tag,
  input  logic                          wr_req_vld,
  output logic                          wr_req_rdy,
  input  logic [ADDR_W-1:0]             wr_req_addr,
  input  logic [DATA_W-1:0]             wr_req_data,
  output logic                          read_vld_a,
  output logic                          read_vld_b,
  output logic                          write_vld_a,
  output logic                          write_vld_b,
  output logic [ADDR_W-1:0]             sram_addr_a,
  output logic [ADDR_W-1:0]             sram_addr_b,
  output logic [DATA_W-1:0]             wr_data_a,
  output logic [DATA_W-1:0]             wr_data_b,
  input  logic [DATA_W-1:0]             rd_data_a,
  input  logic [DATA_W-1:0]             rd_data_b,
  output logic                          rd_rsp_vld,
  output logic [TAG_W-1:0]              rd_rsp_tag,
  output logic [DATA_W-1:0]             rd_rsp_data,
  output logic [$clog2(WBUF_DEPTH):0]   wbuf_cnt
);

  localparam int PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(WBUF_DEPTH) + 1;

  logic [ADDR_W-1:0] wbuf_addr_mem [WBUF_DEPTH];
  logic [DATA_W-1:0] wbuf_data_mem [WBUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              last_wr_grant_reg;

  logic              pipe_vld_reg  [RD_LAT];
  logic [TAG_W-1:0]  pipe_tag_reg  [RD_LAT];
  logic              pipe_inst_reg [RD_LAT];

  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              wbuf_full;
  logic              wbuf_nonempty;
  logic              rd_inst;
  logic              wr_inst;
  logic              raw_block;
  logic              rd_cand;
  logic              wr_cand;
  logic              conflict;
  logic              rd_grant;
  logic              wr_grant;
  logic              push;
  logic              pop;

  assign head_addr     = wbuf_addr_mem[rd_ptr_reg];
  assign head_data     = wbuf_data_mem[rd_ptr_reg];
  assign wbuf_full     = (cnt_reg == CNT_W'(WBUF_DEPTH));
  assign wbuf_nonempty = (cnt_reg != '0);
  assign rd_inst       = rd_req_addr[ADDR_W-1];
  assign wr_inst       = head_addr[ADDR_W-1];

`ifdef VC_SCHED_RAW_CHK_EN
  logic [WBUF_DEPTH-1:0] ent_vld_reg;
  logic [WBUF_DEPTH-1:0] raw_hit;

  for (genvar gi = 0; gi < WBUF_DEPTH; gi++) begin : g_raw
    assign raw_hit[gi] = ent_vld_reg[gi] && (wbuf_addr_mem[gi] == rd_req_addr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_vld_reg <= '0;
    end else begin
      for (int i = 0; i < WBUF_DEPTH; i++) begin
        if (pop && (rd_ptr_reg == PTR_W'(i)))
          ent_vld_reg[i] <= 1'b0;
        if (push && (wr_ptr_reg == PTR_W'(i)))
          ent_vld_reg[i] <= 1'b1;
      end
    end
  end

  assign raw_block = |raw_hit;
`else
  assign raw_block = 1'b0;
`endif

  assign rd_cand  = !rst && rd_req_vld && !raw_block;
  assign wr_cand  = !rst && wbuf_nonempty;
  assign conflict = rd_cand && wr_cand && (rd_inst == wr_inst);

  // Same-instance conflict: a full buffer always wins, otherwise alternate sides.
  always_comb begin
    rd_grant = 1'b0;
    wr_grant = 1'b0;
    if (conflict) begin
      if (wbuf_full || !last_wr_grant_reg)
        wr_grant = 1'b1;
      else
        rd_grant = 1'b1;
    end else begin
      rd_grant = rd_cand;
      wr_grant = wr_cand;
    end
  end

  assign push = wr_req_vld && wr_req_rdy;
  assign pop  = wr_grant;

  assign rd_req_rdy  = rd_grant;
  assign wr_req_rdy  = !rst && !wbuf_full;
  assign wbuf_cnt    = cnt_reg;

  assign read_vld_a  = rd_grant && rd_inst;
  assign read_vld_b  = rd_grant && !rd_inst;
  assign write_vld_a = wr_grant && wr_inst;
  assign write_vld_b = wr_grant && !wr_inst;

  assign sram_addr_a = read_vld_a ? rd_req_addr : (write_vld_a ? head_addr : '0);
  assign sram_addr_b = read_vld_b ? rd_req_addr : (write_vld_b ? head_addr : '0);
  assign wr_data_a   = write_vld_a ? head_data : '0;
  assign wr_data_b   = write_vld_b ? head_data : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      wbuf_addr_mem[wr_ptr_reg] <= wr_req_addr;
      wbuf_data_mem[wr_ptr_reg] <= wr_req_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
      cnt_reg           <= '0;
      last_wr_grant_reg <= 1'b1;
    end else begin
      if (push)
        wr_ptr_reg <= (wr_ptr_reg == PTR_W'(WBUF_DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
      if (pop)
        rd_ptr_reg <= (rd_ptr_reg == PTR_W'(WBUF_DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
      if (push && !pop)
        cnt_reg <= cnt_reg + CNT_W'(1);
      else if (pop && !push)
        cnt_reg <= cnt_reg - CNT_W'(1);
      if (conflict)
        last_wr_grant_reg <= wr_grant;
    end
  end

  // Response pipe: stage RD_LAT-1 lines up with the SRAM data of the issued read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_vld_reg[i]  <= 1'b0;
        pipe_tag_reg[i]  <= '0;
        pipe_inst_reg[i] <= 1'b0;
      end
    end else begin
      pipe_vld_reg[0]  <= rd_grant;
      pipe_tag_reg[0]  <= rd_req_tag;
      pipe_inst_reg[0] <= rd_inst;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld_reg[i]  <= pipe_vld_reg[i-1];
        pipe_tag_reg[i]  <= pipe_tag_reg[i-1];
        pipe_inst_reg[i] <= pipe_inst_reg[i-1];
      end
    end
  end

  assign rd_rsp_vld  = pipe_vld_reg[RD_LAT-1];
  assign rd_rsp_tag  = pipe_vld_reg[RD_LAT-1] ? pipe_tag_reg[RD_LAT-1] : '0;
  assign rd_rsp_data = !pipe_vld_reg[RD_LAT-1] ? '0 :
                       (pipe_inst_reg[RD_LAT-1] ? rd_data_a : rd_data_b);

endmodule

// File: tb/tb_vc_sram_sched.sv
// Directed bench for vc_sram_sched: reset, latency, parallel issue, conflicts, full buffer, RAW, mid-run reset.
module tb_vc_sram_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req_vld;
  logic        rd_req_rdy;
  logic [9:0]  rd_req_addr;
  logic [3:0]  rd_req_tag;
  logic        wr_req_vld;
  logic        wr_req_rdy;
  logic [9:0]  wr_req_addr;
  logic [31:0] wr_req_data;
  logic        read_vld_a, read_vld_b, write_vld_a, write_vld_b;
  logic [9:0]  sram_addr_a, sram_addr_b;
  logic [31:0] wr_data_a, wr_data_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic        rd_rsp_vld;
  logic [3:0]  rd_rsp_tag;
  logic [31:0] rd_rsp_data;
  logic [2:0]  wbuf_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vc_sram_sched dut (
    .clk(clk), .rst(rst),
    .rd_req_vld(rd_req_vld), .rd_req_rdy(rd_req_rdy),
    .rd_req_addr(rd_req_addr), .rd_req_tag(rd_req_tag),
    .wr_req_vld(wr_req_vld), .wr_req_rdy(wr_req_rdy),
    .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
    .read_vld_a(read_vld_a), .read_vld_b(read_vld_b),
    .write_vld_a(write_vld_a), .write_vld_b(write_vld_b),
    .sram_addr_a(sram_addr_a), .sram_addr_b(sram_addr_b),
    .wr_data_a(wr_data_a), .wr_data_b(wr_data_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .rd_rsp_vld(rd_rsp_vld), .rd_rsp_tag(rd_rsp_tag), .rd_rsp_data(rd_rsp_data),
    .wbuf_cnt(wbuf_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Never a read and a write on the same instance in one cycle.
  always @(negedge clk) begin
    checks++;
    assert ((read_vld_a && write_vld_a) === 1'b0 && (read_vld_b && write_vld_b) === 1'b0) else begin
      errors++;
      $error("FAIL same_inst_rw observed=%0b%0b%0b%0b expected=no_rw_pair",
             read_vld_a, write_vld_a, read_vld_b, write_vld_b);
    end
  end

  initial begin
    rst = 1'b1;
    rd_req_vld = 1'b0; rd_req_addr = '0; rd_req_tag = '0;
    wr_req_vld = 1'b0; wr_req_addr = '0; wr_req_data = '0;
    rd_data_a = 32'hAAAA_0001;
    rd_data_b = 32'hBBBB_0002;

    // Reset state
    tick(); tick();
    chk("rst_cnt", wbuf_cnt, 0);
    chk("rst_rsp_vld", rd_rsp_vld, 0);
    chk("rst_wr_rdy", wr_req_rdy, 0);
    rst = 1'b0;
    #1;
    chk("rel_wr_rdy", wr_req_rdy, 1);

    // Lone read to a: same-cycle issue, response RD_LAT=2 later
    rd_req_vld = 1'b1; rd_req_addr = 10'h200; rd_req_tag = 4'd3;
    #1;
    chk("t1_read_vld_a", read_vld_a, 1);
    chk("t1_read_vld_b", read_vld_b, 0);
    chk("t1_sram_addr_a", sram_addr_a, 10'h200);
    chk("t1_rd_rdy", rd_req_rdy, 1);
    tick();
    rd_req_vld = 1'b0;
    #1;
    chk("t1_rsp_early", rd_rsp_vld, 0);
    tick();
    chk("t1_rsp_vld", rd_rsp_vld, 1);
    chk("t1_rsp_tag", rd_rsp_tag, 3);
    chk("t1_rsp_data", rd_rsp_data, 32'hAAAA_0001);
    tick();
    chk("t1_rsp_done", rd_rsp_vld, 0);

    // Write to b accepted at N issues at N+1 alongside a read to a
    wr_req_vld = 1'b1; wr_req_addr = 10'h005; wr_req_data = 32'hDEAD_0005;
    rd_req_vld = 1'b1; rd_req_addr = 10'h210; rd_req_tag = 4'd5;
    #1;
    chk("t2_n_wr_rdy", wr_req_rdy, 1);
    chk("t2_n_no_bypass", write_vld_b, 0);
    chk("t2_n_read_a", read_vld_a, 1);
    tick();
    wr_req_vld = 1'b0; rd_req_tag = 4'd6;
    #1;
    chk("t2_n1_cnt", wbuf_cnt, 1);
    chk("t2_n1_write_b", write_vld_b, 1);
    chk("t2_n1_addr_b", sram_addr_b, 10'h005);
    chk("t2_n1_data_b", wr_data_b, 32'hDEAD_0005);
    chk("t2_n1_read_a", read_vld_a, 1);
    tick();
    rd_req_vld = 1'b0;
    #1;
    chk("t2_n2_cnt", wbuf_cnt, 0);
    chk("t2_n2_write_b", write_vld_b, 0);
    chk("t2_n2_rsp_vld", rd_rsp_vld, 1);
    chk("t2_n2_rsp_tag", rd_rsp_tag, 5);
    tick();
    chk("t2_n3_rsp_vld", rd_rsp_vld, 1);
    chk("t2_n3_rsp_tag", rd_rsp_tag, 6);
    chk("t2_n3_rsp_data", rd_rsp_data, 32'hAAAA_0001);
    tick(); tick();

    // Continuous conflict on a: read, write, read, write
    wr_req_vld = 1'b1; wr_req_addr = 10'h300; wr_req_data = 32'd1;
    rd_req_vld = 1'b1; rd_req_addr = 10'h3F0; rd_req_tag = 4'd1;
    #1;
    chk("t3_m0_read_a", read_vld_a, 1);
    tick();
    wr_req_addr = 10'h301; wr_req_data = 32'd2;
    #1;
    chk("t3_m1_read_a", read_vld_a, 1);
    chk("t3_m1_write_a", write_vld_a, 0);
    tick();
    wr_req_vld = 1'b0;
    #1;
    chk("t3_m2_write_a", write_vld_a, 1);
    chk("t3_m2_read_a", read_vld_a, 0);
    chk("t3_m2_addr_a", sram_addr_a, 10'h300);
    tick();
    chk("t3_m3_read_a", read_vld_a, 1);
    chk("t3_m3_write_a", write_vld_a, 0);
    tick();
    chk("t3_m4_write_a", write_vld_a, 1);
    chk("t3_m4_addr_a", sram_addr_a, 10'h301);
    chk("t3_m4_data_a", wr_data_a, 32'd2);
    tick();
    rd_req_vld = 1'b0;
    #1;
    chk("t3_m5_cnt", wbuf_cnt, 0);
    tick(); tick(); tick();

    // Fill the buffer against a held read to a; full forces the write
    rd_req_vld = 1'b1; rd_req_addr = 10'h3C0; rd_req_tag = 4'd2;
    for (int i = 0; i < 6; i++) begin
      wr_req_vld = 1'b1; wr_req_addr = 10'h380 + 10'(i); wr_req_data = 32'h100 + i;
      #1;
      if (i == 1) chk("t4_p1_read_a", read_vld_a, 1);
      if (i == 2) chk("t4_p2_addr_a", sram_addr_a, 10'h380);
      tick();
    end
    wr_req_vld = 1'b1; wr_req_addr = 10'h386; wr_req_data = 32'h106;
    #1;
    chk("t4_full_cnt", wbuf_cnt, 4);
    chk("t4_full_wr_rdy", wr_req_rdy, 0);
    chk("t4_full_write_a", write_vld_a, 1);
    chk("t4_full_read_a", read_vld_a, 0);
    chk("t4_full_rd_rdy", rd_req_rdy, 0);
    chk("t4_full_addr_a", sram_addr_a, 10'h382);
    chk("t4_full_data_a", wr_data_a, 32'h102);
    tick();
    wr_req_vld = 1'b0; rd_req_vld = 1'b0;
    #1;
    chk("t4_after_cnt", wbuf_cnt, 3);
    for (int i = 0; i < 8 && wbuf_cnt != 0; i++) tick();
    chk("t4_drained_cnt", wbuf_cnt, 0);
    tick(); tick(); tick();

    // Read to a buffered write address
    wr_req_vld = 1'b1; wr_req_addr = 10'h123; wr_req_data = 32'h0000_0123;
    #1;
    tick();
    wr_req_vld = 1'b0;
    rd_req_vld = 1'b1; rd_req_addr = 10'h123; rd_req_tag = 4'd9;
    #1;
`ifdef VC_SCHED_RAW_CHK_EN
    chk("t5_raw_rd_rdy", rd_req_rdy, 0);
    chk("t5_raw_write_b", write_vld_b, 1);
    tick();
    chk("t5_raw_rd_rdy2", rd_req_rdy, 1);
    chk("t5_raw_read_b", read_vld_b, 1);
    chk("t5_raw_addr_b", sram_addr_b, 10'h123);
    tick();
    rd_req_vld = 1'b0;
`else
    chk("t5_pass_rd_rdy", rd_req_rdy, 1);
    chk("t5_pass_read_b", read_vld_b, 1);
    chk("t5_pass_write_b", write_vld_b, 0);
    tick();
    rd_req_vld = 1'b0;
    #1;
    chk("t5_pass_write_b2", write_vld_b, 1);
    chk("t5_pass_addr_b", sram_addr_b, 10'h123);
    tick();
`endif
    #1;
    chk("t5_cnt", wbuf_cnt, 0);
    tick(); tick(); tick();

    // Mid-run reset with 2 buffered writes and reads in flight
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wr_req_vld = 1'b1; wr_req_addr = 10'h050; wr_req_data = 32'h50;
    rd_req_vld = 1'b1; rd_req_addr = 10'h0A0; rd_req_tag = 4'd7;
    #1;
    chk("t6_r0_read_b", read_vld_b, 1);
    tick();
    wr_req_addr = 10'h051; wr_req_data = 32'h51; rd_req_tag = 4'd8;
    #1;
    chk("t6_r1_read_b", read_vld_b, 1);
    chk("t6_r1_write_b", write_vld_b, 0);
    tick();
    wr_req_vld = 1'b0; rd_req_vld = 1'b0;
    #1;
    chk("t6_pre_cnt", wbuf_cnt, 2);
    chk("t6_pre_rsp_tag", rd_rsp_tag, 7);
    rst = 1'b1;
    #1;
    chk("t6_rst_cnt", wbuf_cnt, 0);
    chk("t6_rst_rsp_vld", rd_rsp_vld, 0);
    chk("t6_rst_write_b", write_vld_b, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t6_post_rsp_vld", rd_rsp_vld, 0);
      chk("t6_post_write", {write_vld_a, write_vld_b}, 0);
      chk("t6_post_cnt", wbuf_cnt, 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
